// File: rtl/quant_seq_pkg.sv
// Shared types for the requantization sequencer: command codes, FSM states, channel params.
package quant_seq_pkg;

  localparam logic [6:0] CMD_CLR    = 7'd0;
  localparam logic [6:0] CMD_NUM_CH = 7'd1;
  localparam logic [6:0] CMD_BIAS   = 7'd2;
  localparam logic [6:0] CMD_MULT   = 7'd3;
  localparam logic [6:0] CMD_SHIFT  = 7'd4;
  localparam logic [6:0] CMD_MIN    = 7'd5;
  localparam logic [6:0] CMD_MAX    = 7'd6;
  localparam logic [6:0] CMD_OFF    = 7'd7;
  localparam logic [6:0] CMD_START  = 7'd8;
  localparam logic [6:0] CMD_ABORT  = 7'd9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] bias;
    logic [31:0] mult;
    logic [31:0] shift;
  } ch_param_t;

  // One-hot field select for table-write commands; zero for anything else.
  function automatic logic [2:0] tbl_field(input logic [6:0] c);
    case (c)
      CMD_BIAS:  return 3'b001;
      CMD_MULT:  return 3'b010;
      CMD_SHIFT: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/quant_seq_ctrl_bank.sv
// Per-channel parameter table: one synchronous field write port, one registered read port.
module quant_param_bank
  import quant_seq_pkg::*;
#(
  parameter int MAX_CH = 64,
  parameter int CH_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      we,
  input  logic [CH_W-1:0] waddr,
  input  logic [31:0]     wdata,
  input  logic            re,
  input  logic [CH_W-1:0] raddr,
  output ch_param_t       rdata
);

  ch_param_t tbl [MAX_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CH; i++) tbl[i] <= '0;
      rdata <= '0;
    end else begin
      if (we[0]) tbl[waddr].bias  <= wdata;
      if (we[1]) tbl[waddr].mult  <= wdata;
      if (we[2]) tbl[waddr].shift <= wdata;
      if (re)    rdata <= tbl[raddr];
    end
  end

endmodule

// File: rtl/quant_seq_ctrl.sv
// Requantization sequencer: config regs, channel table, 2-stage stream into the quant datapath.
// Optional QUANT_SEQ_PACK_EN packs four int8 results per output word.
module quant_seq_ctrl
  import quant_seq_pkg::*;
#(
  parameter int MAX_CH     = 64,
  parameter int INT32_SIZE = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [INT32_SIZE-1:0] acc_data,
  output logic [INT32_SIZE-1:0] q_acc,
  output logic [INT32_SIZE-1:0] q_bias,
  output logic [INT32_SIZE-1:0] q_mult,
  output logic [INT32_SIZE-1:0] q_shift,
  output logic [INT32_SIZE-1:0] q_min,
  output logic [INT32_SIZE-1:0] q_max,
  output logic [INT32_SIZE-1:0] q_off,
  input  logic [INT32_SIZE-1:0] q_ret,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INT32_SIZE-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int CH_W   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int STAGES = 2;

  state_e                  state;
  logic [CNT_W-1:0]        total, accepted, acc_nxt;
  logic [INT32_SIZE-1:0]   num_ch, act_min, act_max, out_off;
  logic [CH_W-1:0]         ch, ch_nxt;
  logic [STAGES:1]         vld_pipe;
  logic [INT32_SIZE-1:0]   acc_s1;
  logic                    s1_last, out_last;
  ch_param_t               prm_s1;

  logic stall, acc_fire, out_fire, is_abort, cfg_cmd, busy_err;
  logic tbl_cmd, tbl_oob, ch_last;
  logic [2:0] tbl_we;
  logic unused_q;

  assign busy      = (state != IDLE);
  assign out_valid = vld_pipe[2];
  assign stall     = vld_pipe[2] && !out_ready;
  assign acc_ready = (state == RUN) && !stall;
  assign is_abort  = cmd_valid && (cmd == CMD_ABORT);
  assign acc_fire  = acc_valid && acc_ready && !is_abort;
  assign out_fire  = vld_pipe[2] && out_ready;
  assign acc_nxt   = accepted + 1'b1;

  assign cfg_cmd  = cmd_valid && !busy;
  assign busy_err = cmd_valid && busy && (cmd != CMD_CLR) && (cmd != CMD_ABORT);
  assign tbl_cmd  = cfg_cmd && (|tbl_field(cmd));
  assign tbl_oob  = (inp0 >= INT32_SIZE'(MAX_CH));
  assign tbl_we   = (tbl_cmd && !tbl_oob) ? tbl_field(cmd) : 3'b000;

  // Also wrap at the table end so an oversized num_ch never indexes past it.
  assign ch_last = (INT32_SIZE'(ch) + 1 >= num_ch) || (ch == CH_W'(MAX_CH - 1));
  assign ch_nxt  = ch_last ? '0 : ch + 1'b1;

  quant_param_bank #(.MAX_CH(MAX_CH), .CH_W(CH_W)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (inp0[CH_W-1:0]),
    .wdata (inp1),
    .re    (acc_fire),
    .raddr (ch),
    .rdata (prm_s1)
  );

  assign q_acc   = acc_s1;
  assign q_bias  = prm_s1.bias;
  assign q_mult  = prm_s1.mult;
  assign q_shift = prm_s1.shift;
  assign q_min   = act_min;
  assign q_max   = act_max;
  assign q_off   = out_off;
  assign unused_q = ^q_ret[INT32_SIZE-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      total    <= '0;
      accepted <= '0;
      ch       <= '0;
      num_ch   <= INT32_SIZE'(1);
      act_min  <= '0;
      act_max  <= '0;
      out_off  <= '0;
      cfg_err  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy_err || (tbl_cmd && tbl_oob)) cfg_err <= 1'b1;
      if (cmd_valid && cmd == CMD_CLR)      cfg_err <= 1'b0;
      if (cfg_cmd) begin
        case (cmd)
          CMD_NUM_CH: num_ch  <= (inp1 == '0) ? INT32_SIZE'(1) : inp1;
          CMD_MIN:    act_min <= inp1;
          CMD_MAX:    act_max <= inp1;
          CMD_OFF:    out_off <= inp1;
          CMD_START: begin
            total    <= inp1[CNT_W-1:0];
            accepted <= '0;
            ch       <= '0;
            if (inp1[CNT_W-1:0] == '0) done  <= 1'b1;
            else                       state <= RUN;
          end
          default: ;
        endcase
      end
      case (state)
        RUN: if (acc_fire) begin
          accepted <= acc_nxt;
          ch       <= ch_nxt;
          if (acc_nxt == total) state <= DRAIN;
        end
        DRAIN: if (out_fire && out_last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: ;
      endcase
      if (is_abort) begin
        state <= IDLE;
        done  <= 1'b0;
      end
    end
  end

`ifdef QUANT_SEQ_PACK_EN
  logic [1:0]            byte_idx, idx_base;
  logic [INT32_SIZE-1:0] pack_word;

  // A valid output word can only be advancing past if it is being consumed, so start fresh.
  always_comb begin
    idx_base  = vld_pipe[2] ? 2'd0 : byte_idx;
    pack_word = vld_pipe[2] ? '0 : out_data;
    pack_word[{idx_base, 3'b000} +: 8] = q_ret[7:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      acc_s1   <= '0;
      s1_last  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
`ifdef QUANT_SEQ_PACK_EN
      byte_idx <= '0;
`endif
    end else if (is_abort) begin
      vld_pipe <= '0;
      s1_last  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
`ifdef QUANT_SEQ_PACK_EN
      byte_idx <= '0;
`endif
    end else if (!stall) begin
      vld_pipe[1] <= acc_fire;
      s1_last     <= acc_fire && (acc_nxt == total);
      if (acc_fire) acc_s1 <= acc_data;
`ifdef QUANT_SEQ_PACK_EN
      if (vld_pipe[1]) begin
        out_data    <= pack_word;
        byte_idx    <= idx_base + 2'd1;
        vld_pipe[2] <= (idx_base == 2'd3) || s1_last;
        out_last    <= s1_last;
      end else if (vld_pipe[2]) begin
        vld_pipe[2] <= 1'b0;
        out_data    <= '0;
        byte_idx    <= '0;
        out_last    <= 1'b0;
      end
`else
      vld_pipe[2] <= vld_pipe[1];
      out_last    <= s1_last;
      if (vld_pipe[1]) out_data <= {{(INT32_SIZE-8){q_ret[7]}}, q_ret[7:0]};
`endif
    end
  end

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Self-checking bench for quant_seq_ctrl; the quant datapath is modelled here behind q_ret.
module tb_quant_seq_ctrl;
  import quant_seq_pkg::*;

  localparam int MAX_CH = 64;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [6:0]  cmd = '0;
  logic [31:0] inp0 = '0, inp1 = '0, acc_data = '0;
  logic        acc_valid = 1'b0, acc_ready, out_valid, out_ready = 1'b1;
  logic [31:0] q_acc, q_bias, q_mult, q_shift, q_min, q_max, q_off, q_ret, out_data;
  logic        busy, done, cfg_err;

  int tests = 0, fails = 0;

  logic [31:0] sh_bias [MAX_CH];
  logic [31:0] sh_mult [MAX_CH];
  logic [31:0] sh_shift[MAX_CH];
  logic [31:0] sh_min, sh_max, sh_off;
  int          sh_nch, ch_m, pk_n;
  logic [31:0] pk_word;
  logic [31:0] exp_q[$];
  logic [31:0] acc_list[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] quant_model(input logic [31:0] acc, bias, mult, shift, mn, mx, off);
    longint x, r;
    x = longint'($signed(acc)) + longint'($signed(bias));
    r = (x * longint'($signed(mult)) + 64'sd1073741824) >>> 31;
    r = r >>> shift[4:0];
    r = r + longint'($signed(off));
    if (r < longint'($signed(mn))) r = longint'($signed(mn));
    if (r > longint'($signed(mx))) r = longint'($signed(mx));
    return r[31:0];
  endfunction

  assign q_ret = quant_model(q_acc, q_bias, q_mult, q_shift, q_min, q_max, q_off);

  quant_seq_ctrl #(.MAX_CH(MAX_CH), .INT32_SIZE(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .q_acc(q_acc), .q_bias(q_bias), .q_mult(q_mult), .q_shift(q_shift),
    .q_min(q_min), .q_max(q_max), .q_off(q_off), .q_ret(q_ret),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: condition not met", nm);
  endtask

  task automatic reset_shadow();
    for (int i = 0; i < MAX_CH; i++) begin
      sh_bias[i] = '0; sh_mult[i] = '0; sh_shift[i] = '0;
    end
    sh_min = '0; sh_max = '0; sh_off = '0; sh_nch = 1;
  endtask

  task automatic do_cmd(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; inp0 = a0; inp1 = a1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Drives an idle-time command and tracks its architectural effect in the shadow state.
  task automatic cfg(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1);
    do_cmd(c, a0, a1);
    case (c)
      CMD_NUM_CH: sh_nch = (a1 == 0) ? 1 : int'(a1);
      CMD_BIAS:   if (a0 < MAX_CH) sh_bias[a0]  = a1;
      CMD_MULT:   if (a0 < MAX_CH) sh_mult[a0]  = a1;
      CMD_SHIFT:  if (a0 < MAX_CH) sh_shift[a0] = a1;
      CMD_MIN:    sh_min = a1;
      CMD_MAX:    sh_max = a1;
      CMD_OFF:    sh_off = a1;
      default: ;
    endcase
  endtask

  task automatic push_exp(input logic [31:0] a, input bit last);
    logic [31:0] r;
    r = quant_model(a, sh_bias[ch_m], sh_mult[ch_m], sh_shift[ch_m], sh_min, sh_max, sh_off);
    ch_m = (ch_m + 1 >= sh_nch) ? 0 : ch_m + 1;
`ifdef QUANT_SEQ_PACK_EN
    pk_word[8*pk_n +: 8] = r[7:0];
    pk_n++;
    if (pk_n == 4 || last) begin
      exp_q.push_back(pk_word);
      pk_word = '0; pk_n = 0;
    end
`else
    exp_q.push_back({{24{r[7]}}, r[7:0]});
`endif
  endtask

  // Streams acc_list through a started job; optional out_ready stall and an illegal busy write.
  task automatic run_job(input int stall_len, input bit inj);
    int n, sent, cyc, dones, stall_left;
    bit held_v;
    logic [31:0] held;
    n = acc_list.size();
    sent = 0; cyc = 0; dones = 0; stall_left = -1; held_v = 0; held = '0;
    ch_m = 0; pk_n = 0; pk_word = '0;
    exp_q.delete();
    do_cmd(CMD_START, 0, n);
    while (cyc < 400) begin
      acc_valid = (sent < n);
      acc_data  = (sent < n) ? acc_list[sent] : '0;
      out_ready = !(stall_left > 0);
      cmd_valid = inj && (cyc == 3);
      cmd = CMD_BIAS; inp0 = 0; inp1 = 32'd99;
      #1;
      if (done) begin
        dones++;
        if (sent != n || exp_q.size() != 0) fail("early_done");
      end
      if (out_valid && !out_ready) begin
        chk("stall_acc_ready", acc_ready, 0);
        if (held_v) chk("stall_hold", out_data, held);
        held = out_data; held_v = 1;
      end else if (out_valid) begin
        held_v = 0;
        if (exp_q.size() == 0) fail("extra_out");
        else chk("out_word", out_data, exp_q.pop_front());
      end
      if (acc_valid && acc_ready) begin
        push_exp(acc_list[sent], sent == n - 1);
        sent++;
      end
      if (stall_left > 0) stall_left--;
      if (stall_left < 0 && stall_len > 0 && out_valid) stall_left = stall_len;
      if (dones > 0 && sent == n && exp_q.size() == 0) break;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
    end
    cmd_valid = 1'b0; acc_valid = 1'b0; out_ready = 1'b1;
    if (cyc >= 400) fail("job_timeout");
    chk("job_done_count", dones, 1);
    chk("job_missing_out", exp_q.size(), 0);
    @(negedge clk); #1;
    chk("job_done_low", done, 0);
    chk("job_busy_low", busy, 0);
  endtask

  typedef struct {
    logic [6:0]  c;
    logic [31:0] a0, a1;
    logic        err;
    string       nm;
  } cmd_vec_t;

  cmd_vec_t cv[7];

  initial begin
    int fires, cyc;
    cv[0] = '{CMD_BIAS,  32'd64,         32'd50, 1'b1, "bias_oob"};
    cv[1] = '{CMD_CLR,   32'd0,          32'd0,  1'b0, "clr1"};
    cv[2] = '{CMD_SHIFT, 32'hFFFF_0000,  32'd3,  1'b1, "shift_oob_hi"};
    cv[3] = '{CMD_CLR,   32'd0,          32'd0,  1'b0, "clr2"};
    cv[4] = '{7'd12,     32'd0,          32'd0,  1'b0, "unknown_cmd"};
    cv[5] = '{CMD_MULT,  32'd63,         32'd5,  1'b0, "mult_last_entry"};
    cv[6] = '{CMD_OFF,   32'd0,          32'd0,  1'b0, "offset_zero"};

    reset_shadow();
    #12;
    chk("rst_acc_ready", acc_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_done",      done, 0);
    chk("rst_cfg_err",   cfg_err, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single channel, explicit latency and done timing.
    cfg(CMD_NUM_CH, 0, 1);
    cfg(CMD_BIAS, 0, 0);
    cfg(CMD_MULT, 0, 32'h4000_0000);
    cfg(CMD_SHIFT, 0, 0);
    cfg(CMD_MIN, 0, 32'hFFFF_FF80);
    cfg(CMD_MAX, 0, 32'd127);
    cfg(CMD_OFF, 0, 0);
    do_cmd(CMD_START, 0, 1);
    acc_valid = 1'b1; acc_data = 32'd100; out_ready = 1'b1;
    #1; chk("single_acc_ready", acc_ready, 1); chk("single_busy", busy, 1);
    @(negedge clk); acc_valid = 1'b0;
    #1; chk("single_lat1_valid", out_valid, 0);
    @(negedge clk); #1;
    chk("single_lat2_valid", out_valid, 1);
    chk("single_data", out_data, 32'd50);
    chk("single_no_early_done", done, 0);
    @(negedge clk); #1;
    chk("single_done", done, 1);
    chk("single_idle", busy, 0);
    chk("single_out_clear", out_valid, 0);
    @(negedge clk); #1;
    chk("single_done_pulse", done, 0);

    // Idle-time command table.
    for (int i = 0; i < 7; i++) begin
      cfg(cv[i].c, cv[i].a0, cv[i].a1);
      #1;
      chk(cv[i].nm, cfg_err, cv[i].err);
      chk({cv[i].nm, "_busy"}, busy, 0);
    end

    // Zero-length job: done only.
    do_cmd(CMD_START, 0, 0);
    #1; chk("zero_done", done, 1); chk("zero_busy", busy, 0); chk("zero_out", out_valid, 0);
    @(negedge clk); #1; chk("zero_done_pulse", done, 0);

    // Channel wrap with identity multiplier.
    cfg(CMD_NUM_CH, 0, 3);
    for (int c = 0; c < 3; c++) begin
      cfg(CMD_BIAS, c, 10 * c);
      cfg(CMD_MULT, c, 32'h7FFF_FFFF);
      cfg(CMD_SHIFT, c, 0);
    end
    acc_list = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_job(0, 1'b0);

    // Backpressure with an illegal table write while busy.
    acc_list = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    run_job(5, 1'b1);
    #1; chk("busy_write_err", cfg_err, 1);
    do_cmd(CMD_CLR, 0, 0);
    #1; chk("busy_write_clr", cfg_err, 0);

    // Saturation at both rails.
    acc_list = '{32'hFFFF_FED4, 32'd300, 32'hFFFF_FFFB};
    run_job(0, 1'b0);

    // Six results 1..6 (packs as two words when packing is enabled).
    cfg(CMD_NUM_CH, 0, 1);
    acc_list = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    run_job(0, 1'b0);

    // Abort after three accepts, colliding with an offered accumulator.
    do_cmd(CMD_START, 0, 10);
    fires = 0; cyc = 0;
    while (fires < 3 && cyc < 50) begin
      acc_valid = 1'b1; acc_data = cyc; out_ready = 1'b1;
      #1; if (acc_ready) fires++;
      @(negedge clk); cyc++;
    end
    if (fires < 3) fail("abort_feed_timeout");
    acc_valid = 1'b1; cmd_valid = 1'b1; cmd = CMD_ABORT;
    @(negedge clk); cmd_valid = 1'b0; acc_valid = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_acc_ready", acc_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("abort_no_done", done, 0);
      chk("abort_quiet", out_valid, 0);
    end
    acc_list = '{32'd7, 32'd9};
    run_job(0, 1'b0);

    // Reset mid-job with cfg_err set.
    do_cmd(CMD_BIAS, 32'd64, 0);
    do_cmd(CMD_START, 0, 10);
    fires = 0; cyc = 0;
    while (fires < 4 && cyc < 50) begin
      acc_valid = 1'b1; acc_data = 32'd5; out_ready = 1'b0;
      #1; if (acc_ready) fires++;
      @(negedge clk); cyc++;
    end
    rst_n = 1'b0; acc_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst_acc_ready", acc_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data",  out_data, 0);
    chk("mid_rst_busy",      busy, 0);
    chk("mid_rst_done",      done, 0);
    chk("mid_rst_cfg_err",   cfg_err, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    reset_shadow();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1; chk("post_rst_no_done", done, 0);
    end
    acc_list = '{32'd77};
    run_job(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
